// File: rtl/axil_reg_slice.sv
// axil_reg_slice: AXI4-Lite register slice with one slave (S_AXI_*) and one
// master (M_AXI_*) port. Each of the five channels is independently built as
// a bypass wire (mode 0), a two-entry skid buffer (mode 1) or a one-entry
// light buffer (mode 2). This breaks the combinational VALID, READY and
// payload paths between the interconnect and the peripherals.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  single clock; synchronous active-low reset
//   S_AXI_AW*/W*/B*/AR*/R*     slave side, facing the interconnect
//   M_AXI_AW*/W*/B*/AR*/R*     master side, facing the peripheral
//   wr_outstanding             S-side AW handshakes minus S-side B handshakes
//   rd_outstanding             S-side AR handshakes minus S-side R handshakes
//
// Handshake semantics on every channel: a beat transfers on a rising edge
// where VALID and READY are both high. A VALID that has been raised stays
// high, with its payload unchanged, until that beat transfers. READY may
// rise or fall at any time and never depends on VALID.

// One channel stage. "src" is the side that offers beats, "snk" the side
// that takes them.
module axil_reg_slice_chan #(
  parameter int W    = 8,
  parameter int MODE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [W-1:0] src_data,
  output logic         snk_valid,
  input  logic         snk_ready,
  output logic [W-1:0] snk_data
);

  generate
    if (MODE == 0) begin : g_bypass
      // Plain wires: READY/VALID pass through even while reset is held.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};
      assign snk_valid = src_valid;
      assign snk_data  = src_data;
      assign src_ready = snk_ready;
    end else if (MODE == 1) begin : g_skid
      logic         main_valid, skid_valid, ready_r;
      logic [W-1:0] main_data, skid_data;
      logic         src_hs, snk_hs;

      assign src_hs    = src_valid & ready_r;
      assign snk_hs    = main_valid & snk_ready;
      assign src_ready = ready_r;
      assign snk_valid = main_valid;
      assign snk_data  = main_data;

      // ready_r tracks !skid_valid for the next cycle, but is held low
      // while in reset so the source sees a clean start.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          ready_r    <= 1'b0;
        end else if (!main_valid || snk_hs) begin
          // Main frees up: refill from skid first to keep ordering.
          if (skid_valid) begin
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
          end else begin
            main_valid <= src_hs;
          end
          ready_r <= 1'b1;
        end else if (src_hs) begin
          // Main held by a stalled sink: park the new beat in skid.
          skid_valid <= 1'b1;
          ready_r    <= 1'b0;
        end else begin
          ready_r <= !skid_valid;
        end
      end

      // Payload registers carry no reset; they load only on a transfer.
      always_ff @(posedge clk) begin
        if (!main_valid || snk_hs) begin
          if (skid_valid) main_data <= skid_data;
          else if (src_hs) main_data <= src_data;
        end
        if (main_valid && !snk_hs && src_hs) skid_data <= src_data;
      end
    end else begin : g_light
      logic         valid_r, ready_r;
      logic [W-1:0] data_r;
      logic         src_hs, snk_hs;

      assign src_hs    = src_valid & ready_r;
      assign snk_hs    = valid_r & snk_ready;
      assign src_ready = ready_r;
      assign snk_valid = valid_r;
      assign snk_data  = data_r;

      // ready_r is the registered complement of the next valid, so a load
      // and an unload never fall in the same cycle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_r <= 1'b0;
          ready_r <= 1'b0;
        end else if (src_hs) begin
          valid_r <= 1'b1;
          ready_r <= 1'b0;
        end else if (snk_hs) begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end else begin
          ready_r <= !valid_r;
        end
      end

      always_ff @(posedge clk) begin
        if (src_hs) data_r <= src_data;
      end
    end
  endgenerate

endmodule

module axil_reg_slice #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int C_AW_MODE          = 1,
  parameter int C_W_MODE           = 1,
  parameter int C_B_MODE           = 1,
  parameter int C_AR_MODE          = 1,
  parameter int C_R_MODE           = 1,
  parameter int C_CNT_WIDTH        = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_CNT_WIDTH-1:0]          wr_outstanding,
  output logic [C_CNT_WIDTH-1:0]          rd_outstanding
);

  localparam int AW_W = C_S_AXI_ADDR_WIDTH + 3;
  localparam int WW   = C_S_AXI_DATA_WIDTH + C_S_AXI_DATA_WIDTH / 8;
  localparam int RW   = C_S_AXI_DATA_WIDTH + 2;
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

  logic [AW_W-1:0] aw_out, ar_out;
  logic [WW-1:0]   w_out;
  logic [1:0]      b_out;
  logic [RW-1:0]   r_out;

  axil_reg_slice_chan #(.W(AW_W), .MODE(C_AW_MODE)) u_aw (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .src_valid(S_AXI_AWVALID), .src_ready(S_AXI_AWREADY),
    .src_data({S_AXI_AWPROT, S_AXI_AWADDR}),
    .snk_valid(M_AXI_AWVALID), .snk_ready(M_AXI_AWREADY), .snk_data(aw_out)
  );
  assign {M_AXI_AWPROT, M_AXI_AWADDR} = aw_out;

  axil_reg_slice_chan #(.W(WW), .MODE(C_W_MODE)) u_w (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .src_valid(S_AXI_WVALID), .src_ready(S_AXI_WREADY),
    .src_data({S_AXI_WSTRB, S_AXI_WDATA}),
    .snk_valid(M_AXI_WVALID), .snk_ready(M_AXI_WREADY), .snk_data(w_out)
  );
  assign {M_AXI_WSTRB, M_AXI_WDATA} = w_out;

  axil_reg_slice_chan #(.W(2), .MODE(C_B_MODE)) u_b (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .src_valid(M_AXI_BVALID), .src_ready(M_AXI_BREADY), .src_data(M_AXI_BRESP),
    .snk_valid(S_AXI_BVALID), .snk_ready(S_AXI_BREADY), .snk_data(b_out)
  );
  assign S_AXI_BRESP = b_out;

  axil_reg_slice_chan #(.W(AW_W), .MODE(C_AR_MODE)) u_ar (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .src_valid(S_AXI_ARVALID), .src_ready(S_AXI_ARREADY),
    .src_data({S_AXI_ARPROT, S_AXI_ARADDR}),
    .snk_valid(M_AXI_ARVALID), .snk_ready(M_AXI_ARREADY), .snk_data(ar_out)
  );
  assign {M_AXI_ARPROT, M_AXI_ARADDR} = ar_out;

  axil_reg_slice_chan #(.W(RW), .MODE(C_R_MODE)) u_r (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .src_valid(M_AXI_RVALID), .src_ready(M_AXI_RREADY),
    .src_data({M_AXI_RRESP, M_AXI_RDATA}),
    .snk_valid(S_AXI_RVALID), .snk_ready(S_AXI_RREADY), .snk_data(r_out)
  );
  assign {S_AXI_RRESP, S_AXI_RDATA} = r_out;

  // Debug counters: an address and a response on the same edge cancel;
  // both ends saturate instead of wrapping.
  logic wr_inc, wr_dec, rd_inc, rd_dec;
  assign wr_inc = S_AXI_AWVALID & S_AXI_AWREADY;
  assign wr_dec = S_AXI_BVALID & S_AXI_BREADY;
  assign rd_inc = S_AXI_ARVALID & S_AXI_ARREADY;
  assign rd_dec = S_AXI_RVALID & S_AXI_RREADY;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_outstanding <= '0;
      rd_outstanding <= '0;
    end else begin
      if (wr_inc && !wr_dec && wr_outstanding != '1)
        wr_outstanding <= wr_outstanding + CNT_ONE;
      else if (wr_dec && !wr_inc && wr_outstanding != '0)
        wr_outstanding <= wr_outstanding - CNT_ONE;
      if (rd_inc && !rd_dec && rd_outstanding != '1)
        rd_outstanding <= rd_outstanding + CNT_ONE;
      else if (rd_dec && !rd_inc && rd_outstanding != '0)
        rd_outstanding <= rd_outstanding - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_axil_reg_slice.sv
// Bench for axil_reg_slice. Instance u_a has AW/W/B/AR in skid mode, R in
// light mode and 2-bit counters; instance u_bp has every channel bypassed.
// Expected beats are queued when stimulus is issued and popped by monitors
// whenever the DUT completes a handshake on its output side.
module tb_axil_reg_slice;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instance u_a signals ----------------
  logic        a_rst_n;
  logic [6:0]  a_s_awaddr, a_m_awaddr, a_s_araddr, a_m_araddr;
  logic [2:0]  a_s_awprot, a_m_awprot, a_s_arprot, a_m_arprot;
  logic        a_s_awvalid, a_s_awready, a_m_awvalid, a_m_awready;
  logic [31:0] a_s_wdata, a_m_wdata, a_s_rdata, a_m_rdata;
  logic [3:0]  a_s_wstrb, a_m_wstrb;
  logic        a_s_wvalid, a_s_wready, a_m_wvalid, a_m_wready;
  logic [1:0]  a_s_bresp, a_m_bresp, a_s_rresp, a_m_rresp;
  logic        a_s_bvalid, a_s_bready, a_m_bvalid, a_m_bready;
  logic        a_s_arvalid, a_s_arready, a_m_arvalid, a_m_arready;
  logic        a_s_rvalid, a_s_rready, a_m_rvalid, a_m_rready;
  logic [1:0]  a_wr_out, a_rd_out;

  axil_reg_slice #(.C_AW_MODE(1), .C_W_MODE(1), .C_B_MODE(1), .C_AR_MODE(1),
                   .C_R_MODE(2), .C_CNT_WIDTH(2)) u_a (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(a_rst_n),
    .S_AXI_AWADDR(a_s_awaddr), .S_AXI_AWPROT(a_s_awprot), .S_AXI_AWVALID(a_s_awvalid), .S_AXI_AWREADY(a_s_awready),
    .S_AXI_WDATA(a_s_wdata), .S_AXI_WSTRB(a_s_wstrb), .S_AXI_WVALID(a_s_wvalid), .S_AXI_WREADY(a_s_wready),
    .S_AXI_BRESP(a_s_bresp), .S_AXI_BVALID(a_s_bvalid), .S_AXI_BREADY(a_s_bready),
    .S_AXI_ARADDR(a_s_araddr), .S_AXI_ARPROT(a_s_arprot), .S_AXI_ARVALID(a_s_arvalid), .S_AXI_ARREADY(a_s_arready),
    .S_AXI_RDATA(a_s_rdata), .S_AXI_RRESP(a_s_rresp), .S_AXI_RVALID(a_s_rvalid), .S_AXI_RREADY(a_s_rready),
    .M_AXI_AWADDR(a_m_awaddr), .M_AXI_AWPROT(a_m_awprot), .M_AXI_AWVALID(a_m_awvalid), .M_AXI_AWREADY(a_m_awready),
    .M_AXI_WDATA(a_m_wdata), .M_AXI_WSTRB(a_m_wstrb), .M_AXI_WVALID(a_m_wvalid), .M_AXI_WREADY(a_m_wready),
    .M_AXI_BRESP(a_m_bresp), .M_AXI_BVALID(a_m_bvalid), .M_AXI_BREADY(a_m_bready),
    .M_AXI_ARADDR(a_m_araddr), .M_AXI_ARPROT(a_m_arprot), .M_AXI_ARVALID(a_m_arvalid), .M_AXI_ARREADY(a_m_arready),
    .M_AXI_RDATA(a_m_rdata), .M_AXI_RRESP(a_m_rresp), .M_AXI_RVALID(a_m_rvalid), .M_AXI_RREADY(a_m_rready),
    .wr_outstanding(a_wr_out), .rd_outstanding(a_rd_out)
  );

  // ---------------- instance u_bp signals (all bypass) ----------------
  logic        b_rst_n;
  logic [6:0]  b_s_awaddr, b_m_awaddr, b_s_araddr, b_m_araddr;
  logic [2:0]  b_s_awprot, b_m_awprot, b_s_arprot, b_m_arprot;
  logic        b_s_awvalid, b_s_awready, b_m_awvalid, b_m_awready;
  logic [31:0] b_s_wdata, b_m_wdata, b_s_rdata, b_m_rdata;
  logic [3:0]  b_s_wstrb, b_m_wstrb;
  logic        b_s_wvalid, b_s_wready, b_m_wvalid, b_m_wready;
  logic [1:0]  b_s_bresp, b_m_bresp, b_s_rresp, b_m_rresp;
  logic        b_s_bvalid, b_s_bready, b_m_bvalid, b_m_bready;
  logic        b_s_arvalid, b_s_arready, b_m_arvalid, b_m_arready;
  logic        b_s_rvalid, b_s_rready, b_m_rvalid, b_m_rready;
  logic [3:0]  b_wr_out, b_rd_out;

  axil_reg_slice #(.C_AW_MODE(0), .C_W_MODE(0), .C_B_MODE(0), .C_AR_MODE(0),
                   .C_R_MODE(0)) u_bp (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(b_rst_n),
    .S_AXI_AWADDR(b_s_awaddr), .S_AXI_AWPROT(b_s_awprot), .S_AXI_AWVALID(b_s_awvalid), .S_AXI_AWREADY(b_s_awready),
    .S_AXI_WDATA(b_s_wdata), .S_AXI_WSTRB(b_s_wstrb), .S_AXI_WVALID(b_s_wvalid), .S_AXI_WREADY(b_s_wready),
    .S_AXI_BRESP(b_s_bresp), .S_AXI_BVALID(b_s_bvalid), .S_AXI_BREADY(b_s_bready),
    .S_AXI_ARADDR(b_s_araddr), .S_AXI_ARPROT(b_s_arprot), .S_AXI_ARVALID(b_s_arvalid), .S_AXI_ARREADY(b_s_arready),
    .S_AXI_RDATA(b_s_rdata), .S_AXI_RRESP(b_s_rresp), .S_AXI_RVALID(b_s_rvalid), .S_AXI_RREADY(b_s_rready),
    .M_AXI_AWADDR(b_m_awaddr), .M_AXI_AWPROT(b_m_awprot), .M_AXI_AWVALID(b_m_awvalid), .M_AXI_AWREADY(b_m_awready),
    .M_AXI_WDATA(b_m_wdata), .M_AXI_WSTRB(b_m_wstrb), .M_AXI_WVALID(b_m_wvalid), .M_AXI_WREADY(b_m_wready),
    .M_AXI_BRESP(b_m_bresp), .M_AXI_BVALID(b_m_bvalid), .M_AXI_BREADY(b_m_bready),
    .M_AXI_ARADDR(b_m_araddr), .M_AXI_ARPROT(b_m_arprot), .M_AXI_ARVALID(b_m_arvalid), .M_AXI_ARREADY(b_m_arready),
    .M_AXI_RDATA(b_m_rdata), .M_AXI_RRESP(b_m_rresp), .M_AXI_RVALID(b_m_rvalid), .M_AXI_RREADY(b_m_rready),
    .wr_outstanding(b_wr_out), .rd_outstanding(b_rd_out)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] aw_q[$], w_q[$], b_q[$], ar_q[$], r_q[$];

  task automatic extra_beat(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected beat, expected queue empty at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (a_m_awvalid && a_m_awready) begin
      if (aw_q.size() == 0) extra_beat("aw_order");
      else check("aw_order", 64'({a_m_awprot, a_m_awaddr}), aw_q.pop_front());
    end
    if (a_m_wvalid && a_m_wready) begin
      if (w_q.size() == 0) extra_beat("w_order");
      else check("w_order", 64'({a_m_wstrb, a_m_wdata}), w_q.pop_front());
    end
    if (a_s_bvalid && a_s_bready) begin
      if (b_q.size() == 0) extra_beat("b_order");
      else check("b_order", 64'(a_s_bresp), b_q.pop_front());
    end
    if (a_m_arvalid && a_m_arready) begin
      if (ar_q.size() == 0) extra_beat("ar_order");
      else check("ar_order", 64'({a_m_arprot, a_m_araddr}), ar_q.pop_front());
    end
    if (a_s_rvalid && a_s_rready) begin
      if (r_q.size() == 0) extra_beat("r_order");
      else check("r_order", 64'({a_s_rresp, a_s_rdata}), r_q.pop_front());
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag, input logic [4:0] exp_ready);
    check({tag, "_valids"}, 64'({a_m_awvalid, a_m_wvalid, a_m_arvalid, a_s_bvalid, a_s_rvalid}), 64'(0));
    check({tag, "_readys"}, 64'({a_s_awready, a_s_wready, a_s_arready, a_m_bready, a_m_rready}),
          64'(exp_ready));
    check({tag, "_wr_cnt"}, 64'(a_wr_out), 64'(0));
  endtask

  // One B response from the peripheral, consumed on S, then counter check.
  task automatic send_b(input logic [1:0] resp, input logic [1:0] exp_cnt);
    tick();
    a_m_bvalid = 1'b1;
    a_m_bresp  = resp;
    b_q.push_back(64'(resp));
    tick();
    a_m_bvalid = 1'b0;
    tick();
    @(negedge clk);
    check("wr_cnt_dec", 64'(a_wr_out), 64'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    logic hs;
    logic ok;
    int   idx;

    a_rst_n = 1'b0;
    a_s_awaddr = '0; a_s_awprot = '0; a_s_awvalid = 1'b0;
    a_s_wdata = '0; a_s_wstrb = '0; a_s_wvalid = 1'b0; a_s_bready = 1'b1;
    a_s_araddr = '0; a_s_arprot = '0; a_s_arvalid = 1'b0; a_s_rready = 1'b1;
    a_m_awready = 1'b1; a_m_wready = 1'b1; a_m_bresp = '0; a_m_bvalid = 1'b0;
    a_m_arready = 1'b0; a_m_rdata = '0; a_m_rresp = '0; a_m_rvalid = 1'b0;
    b_rst_n = 1'b0;
    b_s_awaddr = '0; b_s_awprot = '0; b_s_awvalid = 1'b0;
    b_s_wdata = '0; b_s_wstrb = '0; b_s_wvalid = 1'b0; b_s_bready = 1'b0;
    b_s_araddr = '0; b_s_arprot = '0; b_s_arvalid = 1'b0; b_s_rready = 1'b0;
    b_m_awready = 1'b0; b_m_wready = 1'b0; b_m_bresp = '0; b_m_bvalid = 1'b0;
    b_m_arready = 1'b0; b_m_rdata = '0; b_m_rresp = '0; b_m_rvalid = 1'b0;

    // Reset state, then READYs rise on the first edge with reset high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst", 5'b00000);
    tick();
    a_rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_release_readys", 64'({a_s_awready, a_s_wready, a_s_arready, a_m_bready, a_m_rready}),
          64'(5'b11111));

    // 8 back-to-back writes; M beat i-1 is visible while S offers beat i.
    for (int i = 0; i < 8; i++) begin
      tick();
      a_s_awvalid = 1'b1; a_s_awaddr = 7'(i * 4); a_s_awprot = 3'(i);
      a_s_wvalid  = 1'b1; a_s_wdata  = 32'hA0 + 32'(i); a_s_wstrb = 4'(i + 1);
      aw_q.push_back(64'({a_s_awprot, a_s_awaddr}));
      w_q.push_back(64'({a_s_wstrb, a_s_wdata}));
      @(negedge clk);
      check("aw_ready_held", 64'({a_s_awready, a_s_wready}), 64'(2'b11));
      check("aw_m_valid_seq", 64'({a_m_awvalid, a_m_wvalid}), (i > 0) ? 64'(2'b11) : 64'(2'b00));
    end
    tick();
    a_s_awvalid = 1'b0; a_s_wvalid = 1'b0;
    @(negedge clk);
    check("aw_last_beat", 64'({a_m_awvalid, a_m_awaddr}), 64'({1'b1, 7'h1C}));
    @(negedge clk);
    check("aw_drained", 64'({a_m_awvalid, a_m_wvalid}), 64'(0));
    check("wr_cnt_sat", 64'(a_wr_out), 64'(3));

    // B responses bring the saturated counter back down, then stop at 0.
    send_b(2'd0, 2'd2);
    send_b(2'd1, 2'd1);
    send_b(2'd2, 2'd0);
    send_b(2'd3, 2'd0);

    // AR skid: M stalls, two reads accepted, the third waits.
    a_m_arready = 1'b0;
    tick();
    a_s_arvalid = 1'b1; a_s_araddr = 7'h10; a_s_arprot = 3'd1;
    ar_q.push_back(64'({3'd1, 7'h10}));
    @(negedge clk);
    check("ar_ready_1", 64'(a_s_arready), 64'(1));
    tick();
    a_s_araddr = 7'h20; a_s_arprot = 3'd2;
    ar_q.push_back(64'({3'd2, 7'h20}));
    @(negedge clk);
    check("ar_ready_2", 64'(a_s_arready), 64'(1));
    tick();
    a_s_araddr = 7'h30; a_s_arprot = 3'd3;
    ar_q.push_back(64'({3'd3, 7'h30}));
    @(negedge clk);
    check("ar_ready_full", 64'(a_s_arready), 64'(0));
    check("ar_m_hold", 64'({a_m_arvalid, a_m_araddr}), 64'({1'b1, 7'h10}));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ar_ready_stall", 64'(a_s_arready), 64'(0));
    end
    tick();
    a_m_arready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_s_arready) begin
        ok = 1'b1;
        break;
      end
    end
    check("ar_release_timeout", 64'(ok), 64'(1));
    tick();
    a_s_arvalid = 1'b0;
    repeat (3) tick();
    check("ar_none_lost", 64'(ar_q.size()), 64'(0));

    // R light buffer: M_AXI_RREADY alternates, one beat per two cycles.
    idx = 0;
    a_m_rvalid = 1'b1; a_m_rdata = 32'h11; a_m_rresp = 2'd0;
    r_q.push_back(64'({2'd0, 32'h11}));
    r_q.push_back(64'({2'd0, 32'h22}));
    r_q.push_back(64'({2'd0, 32'h33}));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("r_ready_toggle", 64'(a_m_rready), 64'((i % 2) == 0));
      hs = a_m_rready;
      tick();
      if (hs) begin
        idx++;
        if (idx < 3) a_m_rdata = 32'h11 * 32'(idx + 1);
        else a_m_rvalid = 1'b0;
      end
    end
    repeat (3) tick();
    check("r_none_lost", 64'(r_q.size()), 64'(0));

    // Reset with a full W skid and a pending B response.
    a_m_wready = 1'b0; a_s_bready = 1'b0;
    tick();
    a_s_awvalid = 1'b1; a_s_awaddr = 7'h40; a_s_awprot = 3'd0;
    aw_q.push_back(64'({3'd0, 7'h40}));
    a_s_wvalid = 1'b1; a_s_wdata = 32'hB0; a_s_wstrb = 4'hF;
    tick();
    a_s_awvalid = 1'b0; a_s_wdata = 32'hB1;
    tick();
    a_s_wvalid = 1'b0;
    a_m_bvalid = 1'b1; a_m_bresp = 2'd2;
    tick();
    a_m_bvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_w_full", 64'({a_s_wready, a_m_wvalid, a_s_bvalid}), 64'(3'b011));
    check("pre_rst_wr_cnt", 64'(a_wr_out), 64'(1));
    tick();
    a_rst_n = 1'b0;
    w_q.delete();
    tick();
    a_rst_n = 1'b1;
    a_m_wready = 1'b1; a_s_bready = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst", 5'b00000);
    @(negedge clk);
    check("mid_rst_release", 64'({a_s_awready, a_s_wready, a_s_arready, a_m_bready, a_m_rready}),
          64'(5'b11111));

    // Fresh write after reset.
    tick();
    a_s_awvalid = 1'b1; a_s_awaddr = 7'h44; a_s_awprot = 3'd5;
    aw_q.push_back(64'({3'd5, 7'h44}));
    a_s_wvalid = 1'b1; a_s_wdata = 32'hC0; a_s_wstrb = 4'h3;
    w_q.push_back(64'({4'h3, 32'hC0}));
    tick();
    a_s_awvalid = 1'b0; a_s_wvalid = 1'b0;
    @(negedge clk);
    check("post_rst_wr_cnt", 64'(a_wr_out), 64'(1));
    send_b(2'd1, 2'd0);
    repeat (2) tick();
    check("queues_empty", 64'(aw_q.size() + w_q.size() + b_q.size()), 64'(0));

    // Bypass instance: outputs follow inputs in the same cycle, reset or not.
    for (int i = 0; i < 24; i++) begin
      tick();
      b_rst_n = !(i >= 8 && i < 12);
      b_s_awaddr = 7'($urandom); b_s_awprot = 3'($urandom); b_s_awvalid = 1'($urandom);
      b_s_wdata = $urandom; b_s_wstrb = 4'($urandom); b_s_wvalid = 1'($urandom);
      b_s_bready = 1'($urandom);
      b_s_araddr = 7'($urandom); b_s_arprot = 3'($urandom); b_s_arvalid = 1'($urandom);
      b_s_rready = 1'($urandom);
      b_m_awready = 1'($urandom); b_m_wready = 1'($urandom);
      b_m_bresp = 2'($urandom); b_m_bvalid = 1'($urandom);
      b_m_arready = 1'($urandom);
      b_m_rdata = $urandom; b_m_rresp = 2'($urandom); b_m_rvalid = 1'($urandom);
      @(negedge clk);
      check("byp_addr", 64'({b_m_awaddr, b_m_awprot, b_m_awvalid, b_m_araddr, b_m_arprot, b_m_arvalid,
                             b_m_bready, b_m_rready}),
            64'({b_s_awaddr, b_s_awprot, b_s_awvalid, b_s_araddr, b_s_arprot, b_s_arvalid,
                 b_s_bready, b_s_rready}));
      check("byp_wdata", 64'({b_m_wdata, b_m_wstrb, b_m_wvalid}), 64'({b_s_wdata, b_s_wstrb, b_s_wvalid}));
      check("byp_rev", 64'({b_s_awready, b_s_wready, b_s_arready, b_s_bresp, b_s_bvalid,
                            b_s_rdata, b_s_rresp, b_s_rvalid}),
            64'({b_m_awready, b_m_wready, b_m_arready, b_m_bresp, b_m_bvalid,
                 b_m_rdata, b_m_rresp, b_m_rvalid}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_reg_slice.md
Name: axil_reg_slice

Overview:
- Parametrised AXI4-Lite register slice: one slave port, one master port, same address/data widths, independent per-channel pipeline mode.
- Channel order: AW, W, B, AR, R.
- Each channel is a wire, a full two-entry skid buffer, or a one-entry light buffer.
- Sits between the interconnect and PL peripherals on the Ultra96 block design to break timing paths on VALID, READY and payload.
- Adds saturating outstanding-transaction counters for debug.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, RDATA/WDATA width (32 or 64).
- C_S_AXI_ADDR_WIDTH, 7, AWADDR/ARADDR width (1..64).
- C_AW_MODE, 1, AW channel mode: 0 = bypass, 1 = full skid, 2 = light.
- C_W_MODE, 1, W channel mode, same encoding.
- C_B_MODE, 1, B channel mode, same encoding.
- C_AR_MODE, 1, AR channel mode, same encoding.
- C_R_MODE, 1, R channel mode, same encoding.
- C_CNT_WIDTH, 4, width of the outstanding counters.

Ports:
- S_AXI_ACLK  in  1  single clock for both ports
- S_AXI_ARESETN  in  1  synchronous, active-low reset
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR_W/3/1  slave write address
- S_AXI_AWREADY  out  1  slave write address ready
- S_AXI_WDATA/WSTRB/WVALID  in  DATA_W/DATA_W/8/1  slave write data
- S_AXI_WREADY  out  1  slave write data ready
- S_AXI_BRESP/BVALID  out  2/1  slave write response
- S_AXI_BREADY  in  1  slave write response ready
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR_W/3/1  slave read address
- S_AXI_ARREADY  out  1  slave read address ready
- S_AXI_RDATA/RRESP/RVALID  out  DATA_W/2/1  slave read data
- S_AXI_RREADY  in  1  slave read data ready
- M_AXI_*  mirror  same  master-side counterparts of all the above, directions reversed
- wr_outstanding  out  C_CNT_WIDTH  AW handshakes accepted on S minus B handshakes completed on S
- rd_outstanding  out  C_CNT_WIDTH  AR handshakes on S minus R handshakes on S

Behaviour:
- Terminology:
  - Forward channels are AW, W, AR: source = S side, sink = M side.
  - Reverse channels are B, R: source = M side, sink = S side.
  - Each channel has one mode, set by its C_*_MODE, and channels are fully independent.
- Mode 0 (bypass):
  - Pure wires, zero latency, no state.
  - Identical to a direct connection.
- Mode 1 (full skid):
  - Registers: main {valid, payload} plus skid {valid, payload}.
  - Source READY = !skid_valid, driven straight from a register.
  - Sink VALID = main_valid; payload comes from main.
  - Latency is 1 cycle from source handshake to sink VALID.
  - Sustains 1 transfer/cycle with sink READY held high; no bubbles.
  - Source beat arrives while main is full and the sink stalls: the beat goes to skid, and READY drops on the next cycle.
  - Sink handshake with skid full: skid moves to main and skid_valid clears.
  - Simultaneous sink handshake and source handshake with skid empty: the new beat loads main directly; main_valid stays 1.
  - Never more than 2 beats held; no beat is dropped or duplicated.
- Mode 2 (light):
  - One register {valid, payload}.
  - Source READY = !valid, registered.
  - Load on source handshake; clear on sink handshake.
  - Max throughput is 1 beat every 2 cycles; latency is 1 cycle.
- Payload registers are loaded only on handshake; they are never updated while valid and unacknowledged.
- AXI rule: sink VALID, once asserted, stays high with payload stable until the handshake.
- No reordering; AW and W stay decoupled (either may lead).
- Reset (S_AXI_ARESETN = 0 on a clock edge):
  - All valid/skid flags clear: M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, S_AXI_BVALID, S_AXI_RVALID = 0.
  - Buffered-channel READYs = 0 while in reset: S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, M_AXI_BREADY, M_AXI_RREADY.
  - Those READYs go to 1 on the first edge with reset high.
  - Payload registers are not reset (no functional effect).
  - Counters = 0.
  - Reset mid-transfer discards all buffered beats; no partial state survives.
- Bypass channels pass READY/VALID through even during reset; the system resets both sides together.
- Counters:
  - +1 on S-side address handshake, -1 on S-side response handshake; same cycle = unchanged.
  - Saturate at all-ones and at 0; no wrap.

Test Plan:
- All modes 1, M READYs held 1, 8 back-to-back S writes with AWADDR = 0x00..0x1C, WDATA = 0xA0..0xA7 -> M side sees an identical ordered sequence, first M_AXI_AWVALID 1 cycle after the first S handshake, 8 beats on 8 consecutive cycles, S_AXI_AWREADY never drops.
- Mode 1 on AR, M_AXI_ARREADY = 0 for 5 cycles while the S master pushes 3 reads (0x10, 0x20, 0x30) -> two accepted, S_AXI_ARREADY = 0 from the cycle after the second; after release, M sees 0x10, 0x20, 0x30 in order, none lost.
- Mode 2 on R, M_AXI_RVALID held 1 with RDATA 0x11, 0x22, 0x33, S_AXI_RREADY = 1 -> M_AXI_RREADY toggles 1,0,1,0; S sees 0x11, 0x22, 0x33 one per 2 cycles.
- All modes 0 -> every M output equals the corresponding S input in the same cycle over random traffic, including during reset.
- Assert S_AXI_ARESETN = 0 for 1 cycle while the W skid is full and B_VALID is pending -> next cycle all VALIDs = 0, wr_outstanding = 0, READYs = 0; after reset release READYs = 1 and fresh traffic passes cleanly.
- C_CNT_WIDTH = 2, issue 5 writes with S_AXI_BREADY = 0 -> wr_outstanding saturates at 3; 4 B handshakes then return it to 0 with no underflow.
